// File: rtl/branch_ctrl_seq_if.sv
// branch_ctrl_seq_if: handshake and datapath-strobe bundle between the
// branch/fetch control sequencer and the datapath / top-level control unit.
// The sequencer uses the master modport; the side that supplies start,
// mem_ready, IR and bus value and consumes the strobes uses the slave modport.
interface branch_ctrl_seq_if #(
  parameter int DATA_W = 32
) ();

  // Control unit / memory / datapath -> sequencer
  logic              start;
  logic              mem_ready;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] bus_data;

  // Sequencer -> datapath strobes
  logic PCout;
  logic MARin;
  logic Zin;
  logic incPC;
  logic ZLowOut;
  logic PCin;
  logic read;
  logic MDRin;
  logic MDRout;
  logic IRin;
  logic Gra;
  logic Rout;
  logic CONN_in;
  logic Yin;
  logic Cout;

  // Sequencer -> datapath / control unit status
  logic [4:0]        alu_op;
  logic [DATA_W-1:0] c_sext;
  logic [3:0]        step;
  logic              busy;
  logic              done;
  logic              taken;
  logic              illegal;

  modport master (
    input  start, mem_ready, ir, bus_data,
    output PCout, MARin, Zin, incPC, ZLowOut, PCin, read, MDRin,
           MDRout, IRin, Gra, Rout, CONN_in, Yin, Cout,
           alu_op, c_sext, step, busy, done, taken, illegal
  );

  modport slave (
    output start, mem_ready, ir, bus_data,
    input  PCout, MARin, Zin, incPC, ZLowOut, PCin, read, MDRin,
           MDRout, IRin, Gra, Rout, CONN_in, Yin, Cout,
           alu_op, c_sext, step, busy, done, taken, illegal
  );

endinterface

// File: rtl/branch_ctrl_seq.sv
// branch_ctrl_seq: control-step sequencer for instruction fetch and the
// conditional branch class (brzr/brnz/brpl/brmi). A registered state machine
// walks T0..T6 and Moore-decodes the datapath strobes; the branch condition is
// evaluated from the bus value of Ra during T3 and registered as 'taken'.
//
// Optional feature macro: BRANCH_SKIP_EN
//   defined   - a legal but not-taken branch leaves T3 straight for DONE.
//   undefined - every legal branch walks T4..T6 (T6 strobe-free if not taken).
module branch_ctrl_seq #(
  parameter int         DATA_W     = 32,
  parameter logic [4:0] BR_OPCODE  = 5'b10011,
  parameter logic [4:0] ADD_OPCODE = 5'b00001
) (
  input logic               clk,
  input logic               clr,
  branch_ctrl_seq_if.master bus
);

  // State codes double as the externally visible step number.
  typedef enum logic [3:0] {
    IDLE = 4'd0,
    T0   = 4'd1,
    T1   = 4'd2,
    T2   = 4'd3,
    T3   = 4'd4,
    T4   = 4'd5,
    T5   = 4'd6,
    T6   = 4'd7,
    DONE = 4'd8
  } state_t;

  state_t state_q, state_d;
  logic   taken_q, taken_d;
  logic   illegal_q, illegal_d;

  logic [4:0] opcode;
  logic [1:0] c2;
  logic       opcodeOk;
  logic       conResult;
  logic       unusedIr;

  // Opcode lives in the top five IR bits; C2 and the 19-bit offset are fixed.
  assign opcode   = bus.ir[DATA_W-1 -: 5];
  assign c2       = bus.ir[20:19];
  assign opcodeOk = (opcode == BR_OPCODE);

  // The Ra field and other IR bits are not needed by the sequencer itself.
  assign unusedIr = ^bus.ir;

  // Branch offset, sign-extended from IR[18:0]; adding it to PC+1 wraps silently.
  assign bus.c_sext = {{(DATA_W-19){bus.ir[18]}}, bus.ir[18:0]};

  // CON evaluation of the bus value of Ra, selected by C2.
  always_comb begin
    conResult = 1'b0;
    case (c2)
      2'b00:   conResult = (bus.bus_data == '0);
      2'b01:   conResult = (bus.bus_data != '0);
      2'b10:   conResult = ~bus.bus_data[DATA_W-1];
      default: conResult = bus.bus_data[DATA_W-1];
    endcase
  end

  // State, taken and illegal registers; clr forces IDLE and clears status.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= IDLE;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic; status flags clear on entry to T0 and load at the end of T3.
  always_comb begin
    state_d   = state_q;
    taken_d   = taken_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = T0;
          taken_d   = 1'b0;
          illegal_d = 1'b0;
        end
      end
      T0: state_d = T1;
      T1: begin
        if (bus.mem_ready) begin
          state_d = T2;
        end
      end
      T2: state_d = T3;
      T3: begin
        if (!opcodeOk) begin
          illegal_d = 1'b1;
          state_d   = DONE;
        end else begin
          taken_d = conResult;
`ifdef BRANCH_SKIP_EN
          state_d = conResult ? T4 : DONE;
`else
          state_d = T4;
`endif
        end
      end
      T4:      state_d = T5;
      T5:      state_d = T6;
      T6:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore strobe decode from the state register (T3 also looks at the opcode).
  always_comb begin
    bus.PCout   = 1'b0;
    bus.MARin   = 1'b0;
    bus.Zin     = 1'b0;
    bus.incPC   = 1'b0;
    bus.ZLowOut = 1'b0;
    bus.PCin    = 1'b0;
    bus.read    = 1'b0;
    bus.MDRin   = 1'b0;
    bus.MDRout  = 1'b0;
    bus.IRin    = 1'b0;
    bus.Gra     = 1'b0;
    bus.Rout    = 1'b0;
    bus.CONN_in = 1'b0;
    bus.Yin     = 1'b0;
    bus.Cout    = 1'b0;
    bus.alu_op  = 5'b00000;
    case (state_q)
      T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.Zin   = 1'b1;
        bus.incPC = 1'b1;
      end
      T1: begin
        bus.ZLowOut = 1'b1;
        bus.PCin    = 1'b1;
        bus.read    = 1'b1;
        bus.MDRin   = 1'b1;
      end
      T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      T3: begin
        if (opcodeOk) begin
          bus.Gra     = 1'b1;
          bus.Rout    = 1'b1;
          bus.CONN_in = 1'b1;
        end
      end
      T4: begin
        bus.PCout = 1'b1;
        bus.Yin   = 1'b1;
      end
      T5: begin
        bus.Cout   = 1'b1;
        bus.Zin    = 1'b1;
        bus.alu_op = ADD_OPCODE;
      end
      T6: begin
        if (taken_q) begin
          bus.ZLowOut = 1'b1;
          bus.PCin    = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Status outputs decoded from the registers.
  always_comb begin
    bus.step    = state_q;
    bus.busy    = (state_q != IDLE);
    bus.done    = (state_q == DONE);
    bus.taken   = taken_q;
    bus.illegal = illegal_q;
  end

endmodule
